f1_light_sequencer: RTL

Parametrised start-light sequencer, successor to the fixed 8-light F1 FSM.
- A trigger arms the sequence. Lights then fill one per tick-enable pulse until all are lit.
- After the last light, all lights hold for a programmable number of ticks, then go out together, and a one-cycle done pulse is raised.
- Sits between the tick/clock-divider block and the LED bank. Also feeds the reaction-timer logic via done.

---
 rtl/f1_light_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/f1_light_sequencer.sv
// Parametrised F1 start-light sequencer: lights fill one per tick, hold for a
// latched number of ticks, then go out together with a one-cycle done pulse.
module f1_light_sequencer #(
    parameter int NUM_LIGHTS    = 8,
    parameter int DELAY_W       = 7,
    parameter bit FILL_FROM_MSB = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  trigger,
    input  logic                  abort,
    input  logic [DELAY_W-1:0]    delay_val,
    output logic [NUM_LIGHTS-1:0] data_out,
    output logic                  busy,
    output logic                  done
);

    localparam int STEP_W = $clog2(NUM_LIGHTS) + 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_LIGHTS - 1);
    localparam logic [STEP_W-1:0] FULL_STEP = STEP_W'(NUM_LIGHTS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q,  step_d;
    logic [DELAY_W-1:0]  hold_q,  hold_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            hold_q  <= hold_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                step_d = '0;
                hold_d = '0;
                if (trigger) state_d = FILL;
            end
            FILL: begin
                if (abort) begin
                    state_d = IDLE;
                    step_d  = '0;
                end else if (en) begin
                    if (step_q == LAST_STEP) begin
                        state_d = HOLD;
                        step_d  = FULL_STEP;
                        hold_d  = delay_val;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                    step_d  = '0;
                    hold_d  = '0;
                end else if (en) begin
                    if (hold_q == '0) state_d = OUT;
                    else              hold_d  = hold_q - 1'b1;
                end
            end
            OUT: begin
                state_d = IDLE;
                step_d  = '0;
                hold_d  = '0;
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
                hold_d  = '0;
            end
        endcase
    end

    // Outputs decode registered state only; no input reaches an output directly.
    always_comb begin
        data_out = '0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: ;
            FILL: begin
                busy = 1'b1;
                for (int i = 0; i < NUM_LIGHTS; i++) begin
                    if (FILL_FROM_MSB) data_out[NUM_LIGHTS-1-i] = (i < int'(step_q));
                    else               data_out[i]              = (i < int'(step_q));
                end
            end
            HOLD: begin
                busy     = 1'b1;
                data_out = '1;
            end
            OUT: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
